// File: rtl/loop_station.sv
// rtl/loop_station.sv - Looper effect: record, play and overdub a sample loop in shared SRAM
//
// Optional feature macro: LOOP_SAT_EN (saturating overdub write-back; wraps when undefined)
//
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_valid, i_data      input sample strobe and signed sample
//   i_mode               0=STOP 1=RECORD 2=PLAY 3=OVERDUB, captured with each sample
//   i_level              loop/input mix level
//   i_sram_rdata         SRAM read data, valid one cycle after the address
//   o_sram_addr          SRAM address (0 when the bus is idle)
//   o_sram_we_n          SRAM write enable, active low
//   o_sram_wdata         SRAM write data (0 when not writing)
//   o_data, o_valid      processed sample and its one-cycle strobe
//   o_busy               sequencer not idle; new samples are dropped
//   o_record_finish      loop region filled while recording
//   o_loop_len           current loop length in samples
module loop_station #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 20,
   parameter int LEVEL_W    = 3,
   parameter int START_ADDR = 32000,
   parameter int MAX_ADDR   = 671999
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_data,
   input  logic [1:0]        i_mode,
   input  logic [LEVEL_W-1:0] i_level,
   input  logic [DATA_W-1:0] i_sram_rdata,
   output logic [ADDR_W-1:0] o_sram_addr,
   output logic              o_sram_we_n,
   output logic [DATA_W-1:0] o_sram_wdata,
   output logic [DATA_W-1:0] o_data,
   output logic              o_valid,
   output logic              o_busy,
   output logic              o_record_finish,
   output logic [ADDR_W-1:0] o_loop_len
);

   localparam logic [1:0] M_STOP    = 2'd0;
   localparam logic [1:0] M_RECORD  = 2'd1;
   localparam logic [1:0] M_PLAY    = 2'd2;
   localparam logic [1:0] M_OVERDUB = 2'd3;

   localparam logic [ADDR_W-1:0] START_L = ADDR_W'(START_ADDR);
   localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(MAX_ADDR - START_ADDR + 1);
   localparam int                PW      = DATA_W + LEVEL_W + 1;

   typedef enum logic [2:0] {S_IDLE, S_READ, S_LATCH, S_MIX, S_WRITE} state_t;

   state_t state, state_nxt;

   logic [DATA_W-1:0] in_q, loop_q, wdata_q;
   logic [1:0]        mode_q, prev_mode_q;
   logic [ADDR_W-1:0] ptr, len, waddr_q, ptr_adv_q;
   logic              we_q, rec_finish;

   logic              rec_start, rewind, rd_due;
   logic [ADDR_W-1:0] ptr_eff, len_eff, loop_last;
   logic [LEVEL_W:0]  w_in, w_lp;
   logic signed [PW-1:0] p_in, p_lp;
   logic signed [PW:0]   mix_sum;
   logic [DATA_W-1:0] mix_val, od_val;
   logic [DATA_W:0]   od_sum;

   logic [DATA_W-1:0] out_nxt, wdata_nxt;
   logic [ADDR_W-1:0] waddr_nxt, ptr_nxt, len_nxt;
   logic              we_nxt, finish_set;

   // Entering RECORD restarts the region; leaving RECORD rewinds the pointer
   // so that playback of a fresh loop always begins at its first sample.
   always_comb begin
      rec_start = (mode_q == M_RECORD) && (prev_mode_q != M_RECORD);
      rewind    = rec_start || ((mode_q != M_RECORD) && (prev_mode_q == M_RECORD));
      ptr_eff   = rewind ? START_L : ptr;
      len_eff   = rec_start ? '0 : len;
      rd_due    = ((mode_q == M_PLAY) || (mode_q == M_OVERDUB)) && (len_eff != '0);
      loop_last = START_L + len_eff - ADDR_W'(1);
   end

   // Weights always total 2^LEVEL_W, so the shifted sum fits DATA_W.
   always_comb begin
      w_in    = {1'b0, ~i_level};
      w_lp    = {1'b0, i_level} + (LEVEL_W + 1)'(1);
      p_in    = $signed({{(LEVEL_W + 1){in_q[DATA_W-1]}}, in_q})
              * $signed({{DATA_W{1'b0}}, w_in});
      p_lp    = $signed({{(LEVEL_W + 1){loop_q[DATA_W-1]}}, loop_q})
              * $signed({{DATA_W{1'b0}}, w_lp});
      mix_sum = $signed({p_in[PW-1], p_in}) + $signed({p_lp[PW-1], p_lp});
      mix_val = DATA_W'(mix_sum >>> LEVEL_W);
   end

   always_comb begin
      od_sum = {in_q[DATA_W-1], in_q} + {loop_q[DATA_W-1], loop_q};
`ifdef LOOP_SAT_EN
      if (od_sum[DATA_W] != od_sum[DATA_W-1]) begin
         od_val = od_sum[DATA_W] ? {1'b1, {(DATA_W - 1){1'b0}}}
                                 : {1'b0, {(DATA_W - 1){1'b1}}};
      end else begin
         od_val = od_sum[DATA_W-1:0];
      end
`else
      od_val = DATA_W'(od_sum);
`endif
   end

   // Result of the MIX cycle, registered into the WRITE cycle.
   always_comb begin
      out_nxt    = in_q;
      we_nxt     = 1'b0;
      waddr_nxt  = '0;
      wdata_nxt  = '0;
      ptr_nxt    = ptr_eff;
      len_nxt    = len_eff;
      finish_set = 1'b0;
      case (mode_q)
         M_RECORD: begin
            if (len_eff < DEPTH_L) begin
               we_nxt    = 1'b1;
               waddr_nxt = ptr_eff;
               wdata_nxt = in_q;
               ptr_nxt   = ptr_eff + ADDR_W'(1);
               len_nxt   = len_eff + ADDR_W'(1);
            end else begin
               finish_set = 1'b1;
            end
         end
         M_PLAY, M_OVERDUB: begin
            if (rd_due) begin
               out_nxt = mix_val;
               ptr_nxt = (ptr_eff == loop_last) ? START_L : ptr_eff + ADDR_W'(1);
               if (mode_q == M_OVERDUB) begin
                  we_nxt    = 1'b1;
                  waddr_nxt = ptr_eff;
                  wdata_nxt = od_val;
               end
            end
         end
         default: ptr_nxt = START_L;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      o_sram_addr  = '0;
      o_sram_we_n  = 1'b1;
      o_sram_wdata = '0;
      o_valid      = 1'b0;
      case (state)
         S_IDLE: begin
            if (i_valid) state_nxt = S_READ;
         end
         S_READ: begin
            state_nxt = S_LATCH;
            if (rd_due) o_sram_addr = ptr_eff;
         end
         S_LATCH: begin
            state_nxt = S_MIX;
            if (rd_due) o_sram_addr = ptr_eff;
         end
         S_MIX: state_nxt = S_WRITE;
         S_WRITE: begin
            state_nxt = S_IDLE;
            o_valid   = 1'b1;
            if (we_q) begin
               o_sram_addr  = waddr_q;
               o_sram_we_n  = 1'b0;
               o_sram_wdata = wdata_q;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         in_q        <= '0;
         loop_q      <= '0;
         wdata_q     <= '0;
         mode_q      <= M_STOP;
         prev_mode_q <= M_STOP;
         ptr         <= START_L;
         len         <= '0;
         waddr_q     <= '0;
         ptr_adv_q   <= START_L;
         we_q        <= 1'b0;
         rec_finish  <= 1'b0;
         o_data      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_valid) begin
                  in_q        <= i_data;
                  mode_q      <= i_mode;
                  prev_mode_q <= mode_q;
                  if (i_mode != M_RECORD) rec_finish <= 1'b0;
               end
            end
            S_LATCH: loop_q <= i_sram_rdata;
            S_MIX: begin
               o_data    <= out_nxt;
               we_q      <= we_nxt;
               waddr_q   <= waddr_nxt;
               wdata_q   <= wdata_nxt;
               ptr_adv_q <= ptr_nxt;
               len       <= len_nxt;
               if (finish_set) rec_finish <= 1'b1;
            end
            S_WRITE: begin
               ptr  <= ptr_adv_q;
               we_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign o_busy          = (state != S_IDLE);
   assign o_record_finish = rec_finish;
   assign o_loop_len      = len;

endmodule

// File: tb/tb_loop_station.sv
// tb/tb_loop_station.sv - Scoreboard bench for loop_station
module tb_loop_station;
   localparam int DW = 16;
   localparam int AW = 20;
   localparam int LW = 3;
   localparam int SA = 32000;
   localparam int MA = 32003;
`ifdef LOOP_SAT_EN
   localparam int OD_W = 32767;
`else
   localparam int OD_W = -25536;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_valid = 1'b0;
   logic [DW-1:0] i_data = '0;
   logic [1:0]    i_mode = '0;
   logic [LW-1:0] i_level = '0;
   logic [DW-1:0] sram_rdata = '0;
   logic [AW-1:0] sram_addr;
   logic          sram_we_n;
   logic [DW-1:0] sram_wdata;
   logic [DW-1:0] o_data;
   logic          o_valid, o_busy, o_record_finish;
   logic [AW-1:0] o_loop_len;

   logic [DW-1:0] mem [0:63];

   int cyc = 0;
   int errors = 0;
   int checks = 0;
   int last_rd = 0;

   typedef struct {
      int cyc;
      int data;
      int waddr;
      int wdata;
      int len;
      int fin;
      int rd;
   } exp_t;
   exp_t q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (!sram_we_n) mem[sram_addr[5:0]] <= sram_wdata;
      sram_rdata <= mem[sram_addr[5:0]];
   end

   loop_station #(.DATA_W(DW), .ADDR_W(AW), .LEVEL_W(LW), .START_ADDR(SA), .MAX_ADDR(MA)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_data(i_data), .i_mode(i_mode),
      .i_level(i_level), .i_sram_rdata(sram_rdata), .o_sram_addr(sram_addr),
      .o_sram_we_n(sram_we_n), .o_sram_wdata(sram_wdata), .o_data(o_data), .o_valid(o_valid),
      .o_busy(o_busy), .o_record_finish(o_record_finish), .o_loop_len(o_loop_len)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops one expectation per o_valid; also tracks read addresses
   // and flags any write outside an output cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) last_rd = 0;
         if (o_valid) begin
            if (q.size() == 0) begin
               chk("o_valid_unexpected", int'(o_valid), 0);
            end else begin
               e = q.pop_front();
               chk("latency_cycle", cyc, e.cyc);
               chk("o_data", int'($signed(o_data)), e.data);
               chk("o_loop_len", int'(o_loop_len), e.len);
               chk("o_record_finish", int'(o_record_finish), e.fin);
               chk("o_busy", int'(o_busy), 1);
               chk("write_enable", int'(!sram_we_n), (e.waddr >= 0) ? 1 : 0);
               chk("write_addr", int'(sram_addr), (e.waddr >= 0) ? e.waddr : 0);
               chk("write_data", int'($signed(sram_wdata)), (e.waddr >= 0) ? e.wdata : 0);
               chk("read_addr", last_rd, e.rd);
            end
            last_rd = 0;
         end else begin
            if (!sram_we_n) chk("stray_write_we_n", int'(sram_we_n), 1);
            if (sram_we_n && sram_addr != '0) last_rd = int'(sram_addr);
         end
      end
   end

   // waddr < 0 means no write expected; rd = 0 means no read expected.
   task automatic smp(input logic [1:0] m, input int lvl, input int din, input int e_data,
                      input int e_waddr, input int e_wdata, input int e_len, input int e_fin,
                      input int e_rd, input bit glitch = 1'b0);
      exp_t e;
      @(posedge clk); #1;
      i_mode  = m;
      i_level = LW'(lvl);
      i_data  = DW'(din);
      i_valid = 1'b1;
      e.cyc = cyc + 4; e.data = e_data; e.waddr = e_waddr; e.wdata = e_wdata;
      e.len = e_len; e.fin = e_fin; e.rd = e_rd;
      q.push_back(e);
      @(posedge clk); #1;
      i_valid = 1'b0;
      @(posedge clk); #1;
      if (glitch) begin
         i_valid = 1'b1;
         i_data  = DW'(999);
      end
      @(posedge clk); #1;
      i_valid = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, pending=%0d", q.size());
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_o_data", int'(o_data), 0);
      chk("rst_o_valid", int'(o_valid), 0);
      chk("rst_o_busy", int'(o_busy), 0);
      chk("rst_o_record_finish", int'(o_record_finish), 0);
      chk("rst_o_loop_len", int'(o_loop_len), 0);
      chk("rst_we_n", int'(sram_we_n), 1);
      chk("rst_addr", int'(sram_addr), 0);
      chk("rst_wdata", int'(sram_wdata), 0);
      @(posedge clk); #1 rst_n = 1'b1;

      // record 4 samples
      smp(2'd1, 0, 100, 100, SA + 0, 100, 1, 0, 0);
      smp(2'd1, 0, 200, 200, SA + 1, 200, 2, 0, 0);
      smp(2'd1, 0, 300, 300, SA + 2, 300, 3, 0, 0);
      smp(2'd1, 0, 400, 400, SA + 3, 400, 4, 0, 0);
      // play with wrap, loop weight 8/8
      smp(2'd2, 7, 0, 100, -1, 0, 4, 0, SA + 0);
      smp(2'd2, 7, 0, 200, -1, 0, 4, 0, SA + 1);
      smp(2'd2, 7, 0, 300, -1, 0, 4, 0, SA + 2);
      smp(2'd2, 7, 0, 400, -1, 0, 4, 0, SA + 3);
      smp(2'd2, 7, 0, 100, -1, 0, 4, 0, SA + 0);
      smp(2'd2, 7, 0, 200, -1, 0, 4, 0, SA + 1);
      smp(2'd2, 7, 0, 300, -1, 0, 4, 0, SA + 2);
      // (4*800 + 4*400) >>> 3 = 600
      smp(2'd2, 3, 800, 600, -1, 0, 4, 0, SA + 3);
      // stop: passthrough, no access
      smp(2'd0, 0, 55, 55, -1, 0, 4, 0, 0);
      // new loop 8, 30000, -1, 7
      smp(2'd1, 0, 8, 8, SA + 0, 8, 1, 0, 0);
      smp(2'd1, 0, 30000, 30000, SA + 1, 30000, 2, 0, 0);
      smp(2'd1, 0, -1, -1, SA + 2, -1, 3, 0, 0);
      smp(2'd1, 0, 7, 7, SA + 3, 7, 4, 0, 0);
      // (7*-8 + 8) >>> 3 = -6
      smp(2'd2, 0, -8, -6, -1, 0, 4, 0, SA + 0);
      // overdub 10000 onto 30000 at the address just read
      smp(2'd3, 7, 10000, 30000, SA + 1, OD_W, 4, 0, SA + 1);
      // confirm write-back
      smp(2'd0, 7, 0, 0, -1, 0, 4, 0, 0);
      smp(2'd2, 7, 0, 8, -1, 0, 4, 0, SA + 0);
      smp(2'd2, 7, 0, OD_W, -1, 0, 4, 0, SA + 1);
      // region full: 6 records into a 4-word region, busy glitch on the 5th
      smp(2'd1, 0, 11, 11, SA + 0, 11, 1, 0, 0);
      smp(2'd1, 0, 12, 12, SA + 1, 12, 2, 0, 0);
      smp(2'd1, 0, 13, 13, SA + 2, 13, 3, 0, 0);
      smp(2'd1, 0, 14, 14, SA + 3, 14, 4, 0, 0);
      smp(2'd1, 0, 15, 15, -1, 0, 4, 1, 0, 1'b1);
      smp(2'd1, 0, 16, 16, -1, 0, 4, 1, 0);
      smp(2'd2, 7, 0, 11, -1, 0, 4, 0, SA + 0);
      repeat (4) @(posedge clk);
      chk("queue_drained", q.size(), 0);

      // async reset while the sequencer is in MIX
      @(posedge clk); #1;
      i_mode = 2'd3; i_level = '0; i_data = DW'(1234); i_valid = 1'b1;
      @(posedge clk); #1 i_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("abort_o_valid", int'(o_valid), 0);
      chk("abort_we_n", int'(sram_we_n), 1);
      chk("abort_o_loop_len", int'(o_loop_len), 0);
      chk("abort_o_busy", int'(o_busy), 0);
      chk("abort_addr", int'(sram_addr), 0);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (8) @(posedge clk);
      @(negedge clk);
      chk("abort_queue_empty", q.size(), 0);
      chk("abort_idle_busy", int'(o_busy), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/loop_station.md
Name: loop_station

Overview:
- Parametrised successor to the single-track looper effect.
- Records an audio loop into external SRAM, then plays it back mixed with live input.
- Adds an overdub mode: live input is summed into the stored loop and written back.
- Sits in the effect chain between the codec sample source and the next effect. Shares the SRAM port under control of the top FSM.

Parameters:
- DATA_W, 16, signed sample width.
- ADDR_W, 20, SRAM address width.
- LEVEL_W, 3, width of the mix level control.
- START_ADDR, 32000, first SRAM word of the loop region.
- MAX_ADDR, 671999, last SRAM word of the loop region. DEPTH = MAX_ADDR-START_ADDR+1.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset
- i_valid  in  1  one-cycle input sample strobe
- i_data  in  DATA_W  signed input sample
- i_mode  in  2  0=STOP, 1=RECORD, 2=PLAY, 3=OVERDUB
- i_level  in  LEVEL_W  unsigned loop/input mix level
- i_sram_rdata  in  DATA_W  SRAM read data, valid one cycle after address
- o_sram_addr  out  ADDR_W  SRAM address
- o_sram_we_n  out  1  SRAM write enable, active low
- o_sram_wdata  out  DATA_W  SRAM write data
- o_data  out  DATA_W  signed processed sample
- o_valid  out  1  one-cycle output strobe
- o_busy  out  1  sequencer not in IDLE
- o_record_finish  out  1  loop region full while recording
- o_loop_len  out  ADDR_W  current loop length in samples

Behaviour:
- Reset: i_rst_n, asynchronous, active-low; clock i_clk. All registers clear.
  - Outputs at reset: o_data=0, o_valid=0, o_busy=0, o_record_finish=0, o_loop_len=0, o_sram_we_n=1, o_sram_addr=0, o_sram_wdata=0.
  - Internal at reset: ptr=START_ADDR, sequencer=IDLE.
- Sequencer states: IDLE -> READ -> LATCH -> MIX -> WRITE -> IDLE.
  - IDLE: on i_valid, capture i_data and i_mode (mode_q) and go to READ. Without i_valid, stay in IDLE.
  - READ: o_sram_addr=ptr. Read only when mode_q is PLAY or OVERDUB and len>0.
  - LATCH: address held; loop_q <= i_sram_rdata.
  - MIX: compute result and write data into registers.
  - WRITE: o_sram_addr=ptr, o_sram_we_n=0 iff a write is due. o_data is updated and o_valid=1 in this cycle. Pointer advances at the end of this cycle.
- Latency: i_valid at cycle 0 -> o_valid at cycle 4. Next sample is accepted from cycle 5.
- i_valid while o_busy=1 is ignored. The sample is dropped and no state changes.
- Idle bus: in IDLE and in unused cycles, o_sram_we_n=1, addr=0, wdata=0.
- Mode transition into RECORD (mode_q=RECORD, previous mode_q not RECORD): len=0 and ptr=START_ADDR before the write.
- RECORD:
  - Output = captured input.
  - If len<DEPTH: write input at ptr, ptr+1, len+1.
  - If len==DEPTH: no write, o_record_finish=1. The flag stays high until mode_q leaves RECORD.
- PLAY: output = mix. No write.
- OVERDUB:
  - Output = mix.
  - Write sat(input+loop) at the same ptr that was read.
- PLAY/OVERDUB wrap: if ptr==START_ADDR+len-1, ptr=START_ADDR; else ptr+1.
- PLAY/OVERDUB with len==0: passthrough output, no SRAM access, ptr unchanged.
- STOP: passthrough output, no SRAM access, ptr=START_ADDR, len retained. A later PLAY restarts from the loop start.
- Mix arithmetic, with N=2^LEVEL_W:
  - Input weight = N-1-level, loop weight = level+1.
  - Products are signed, DATA_W+LEVEL_W+1 bits wide. The sum is one bit wider and is arithmetic-shifted right by LEVEL_W, then truncated to DATA_W. It always fits.
  - Example, level=0: (7*in + loop)>>>3.
- o_loop_len = len register, updated in the WRITE cycle.
- Reset mid-operation aborts the sequence: no o_valid and we_n returns high immediately.

Optional Feature:
- Macro LOOP_SAT_EN.
- Defined: the overdub sum is computed at DATA_W+1 bits and clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Undefined: the overdub sum is truncated to DATA_W bits (two's-complement wrap).
- Mix path is unaffected in both cases.

Test Plan:
- Reset, then record: mode=RECORD, 4 samples 100,200,300,400.
  - Writes at 32000..32003, o_loop_len=4, o_data equals input each time.
  - o_valid arrives exactly 4 cycles after each i_valid.
- Play wrap: after the above, mode=PLAY, level=7, input 0, 6 samples.
  - Reads 32000,32001,32002,32003,32000,32001.
  - o_data = 100,200,300,400,100,200 (weight 8/8 loop).
- Mix: level=3, input 800, loop 400 -> o_data = (4*800+4*400)>>>3 = 600.
  - level=0, input -8, loop 8 -> (-56+8)>>>3 = -6.
- Overdub: loop 30000, input 10000.
  - With LOOP_SAT_EN: wdata=32767.
  - Without LOOP_SAT_EN: wdata=-25536.
  - Write address equals the read address.
- Full region: MAX_ADDR=START_ADDR+3, record 6 samples.
  - 4 writes only; o_record_finish=1 from the 5th sample until mode=PLAY.
  - An i_valid pulsed during o_busy produces no extra o_valid.
- Async reset asserted in MIX: o_valid never pulses, o_sram_we_n=1 and o_loop_len=0 immediately, no write occurs.
